// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic ALU_OP_DIV = 1'b0;
    localparam logic ALU_OP_MUL = 1'b1;

    localparam int unsigned MULDIV_WIDTH = 16;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply step or restoring divide step.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int unsigned L = MULDIV_WIDTH
) (
    input  logic         op_i,
    input  logic [L-1:0] hi_i,
    input  logic [L-1:0] lo_i,
    input  logic [L-1:0] aux_i,
    input  logic [L-1:0] operand_i,
    output logic [L-1:0] hi_o,
    output logic [L-1:0] lo_o,
    output logic [L-1:0] aux_o
);

    logic [L:0] sum_s;
    logic [L:0] rem_sh_s;
    logic [L:0] diff_s;

    // Next accumulator/remainder, low half/quotient and multiplier for the selected op
    always_comb begin
        sum_s    = {1'b0, hi_i} + {1'b0, operand_i};
        rem_sh_s = {hi_i, lo_i[L-1]};
        diff_s   = rem_sh_s - {1'b0, operand_i};
        hi_o     = hi_i;
        lo_o     = lo_i;
        aux_o    = aux_i;
        case (op_i)
            ALU_OP_MUL: begin
                // The carry out of the add becomes the new top bit after the shift
                if (aux_i[0]) begin
                    hi_o = sum_s[L:1];
                    lo_o = {sum_s[0], lo_i[L-1:1]};
                end else begin
                    hi_o = {1'b0, hi_i[L-1:1]};
                    lo_o = {hi_i[0], lo_i[L-1:1]};
                end
                aux_o = {1'b0, aux_i[L-1:1]};
            end
            ALU_OP_DIV: begin
                if (!diff_s[L]) begin
                    hi_o = diff_s[L-1:0];
                    lo_o = {lo_i[L-2:0], 1'b1};
                end else begin
                    hi_o = rem_sh_s[L-1:0];
                    lo_o = {lo_i[L-2:0], 1'b0};
                end
                aux_o = aux_i;
            end
            default: begin
                hi_o  = hi_i;
                lo_o  = lo_i;
                aux_o = aux_i;
            end
        endcase
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide unit: FSM, iteration counter and registered results.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned L = MULDIV_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         alu_op,
    input  logic [L-1:0] operand_a,
    input  logic [L-1:0] operand_b,
    output logic         busy,
    output logic         done,
    output logic [L-1:0] result,
    output logic [L-1:0] result_hi,
    output logic         overflow,
    output logic         div_by_zero,
    output logic         zero
);

    localparam int unsigned  LAST     = L - 1;
    localparam logic [L-1:0] CNT_LAST = LAST[L-1:0];
    localparam logic [L-1:0] CNT_ONE  = {{(L-1){1'b0}}, 1'b1};

    state_e       state_q, state_d;
    logic [L-1:0] cnt_q, cnt_d;
    logic         op_q, op_d;
    logic [L-1:0] opnd_q, opnd_d;
    logic [L-1:0] hi_q, hi_d;
    logic [L-1:0] lo_q, lo_d;
    logic [L-1:0] aux_q, aux_d;
    logic [L-1:0] result_q, result_d;
    logic [L-1:0] result_hi_q, result_hi_d;
    logic         ovf_q, ovf_d;
    logic         dbz_q, dbz_d;
    logic         zero_q, zero_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    logic [L-1:0] step_hi_s;
    logic [L-1:0] step_lo_s;
    logic [L-1:0] step_aux_s;

    muldiv_step #(.L(L)) u_step (
        .op_i      (op_q),
        .hi_i      (hi_q),
        .lo_i      (lo_q),
        .aux_i     (aux_q),
        .operand_i (opnd_q),
        .hi_o      (step_hi_s),
        .lo_o      (step_lo_s),
        .aux_o     (step_aux_s)
    );

    // Next-state, datapath loading and final result capture
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        opnd_d      = opnd_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        aux_d       = aux_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        ovf_d       = ovf_q;
        dbz_d       = dbz_q;
        zero_d      = zero_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    op_d  = alu_op;
                    cnt_d = {L{1'b0}};
                    hi_d  = {L{1'b0}};
                    // Divide by zero bypasses the iterations and reports immediately
                    if ((alu_op == ALU_OP_DIV) && (operand_b == {L{1'b0}})) begin
                        state_d     = ST_DONE;
                        opnd_d      = {L{1'b0}};
                        lo_d        = {L{1'b0}};
                        aux_d       = {L{1'b0}};
                        result_d    = {L{1'b1}};
                        result_hi_d = operand_a;
                        ovf_d       = 1'b0;
                        dbz_d       = 1'b1;
                        zero_d      = 1'b0;
                    end else if (alu_op == ALU_OP_MUL) begin
                        state_d = ST_RUN;
                        opnd_d  = operand_a;
                        lo_d    = {L{1'b0}};
                        aux_d   = operand_b;
                    end else begin
                        state_d = ST_RUN;
                        opnd_d  = operand_b;
                        lo_d    = operand_a;
                        aux_d   = {L{1'b0}};
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                hi_d  = step_hi_s;
                lo_d  = step_lo_s;
                aux_d = step_aux_s;
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d     = ST_DONE;
                    result_d    = step_lo_s;
                    result_hi_d = step_hi_s;
                    ovf_d       = (op_q == ALU_OP_MUL) && (step_hi_s != {L{1'b0}});
                    dbz_d       = 1'b0;
                    zero_d      = (step_lo_s == {L{1'b0}});
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    // State, datapath and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {L{1'b0}};
            op_q        <= 1'b0;
            opnd_q      <= {L{1'b0}};
            hi_q        <= {L{1'b0}};
            lo_q        <= {L{1'b0}};
            aux_q       <= {L{1'b0}};
            result_q    <= {L{1'b0}};
            result_hi_q <= {L{1'b0}};
            ovf_q       <= 1'b0;
            dbz_q       <= 1'b0;
            zero_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            opnd_q      <= opnd_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            aux_q       <= aux_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            ovf_q       <= ovf_d;
            dbz_q       <= dbz_d;
            zero_q      <= zero_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign result      = result_q;
    assign result_hi   = result_hi_q;
    assign overflow    = ovf_q;
    assign div_by_zero = dbz_q;
    assign zero        = zero_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit; cycle numbers are relative to the start cycle.
module tb_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        alu_op;
    logic [15:0] operand_a;
    logic [15:0] operand_b;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic [15:0] result_hi;
    logic        overflow;
    logic        div_by_zero;
    logic        zero;

    int unsigned edge_cnt;
    int unsigned t0;
    int          errors;
    int          checks;
    int          rel;
    int          nbusy;
    int          ndone;

    muldiv_unit dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .alu_op      (alu_op),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .result_hi   (result_hi),
        .overflow    (overflow),
        .div_by_zero (div_by_zero),
        .zero        (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive a start pulse during cycle 0; returns at the sampling point of cycle 1
    task automatic issue(input logic op, input logic [15:0] a, input logic [15:0] b);
        t0        = edge_cnt;
        start     = 1'b1;
        alu_op    = op;
        operand_a = a;
        operand_b = b;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic wait_done(output int r, output int nb);
        nb = 0;
        for (int i = 0; i < 80; i++) begin
            if (done) break;
            if (busy) nb++;
            @(negedge clk);
        end
        r = int'(edge_cnt - t0);
    endtask

    task automatic chk_outs(input string tag, input logic [15:0] res, input logic [15:0] hi,
                            input logic ovf, input logic dbz, input logic zr);
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_result"}, {16'd0, result}, {16'd0, res});
        chk({tag, "_result_hi"}, {16'd0, result_hi}, {16'd0, hi});
        chk({tag, "_overflow"}, {31'd0, overflow}, {31'd0, ovf});
        chk({tag, "_div_by_zero"}, {31'd0, div_by_zero}, {31'd0, dbz});
        chk({tag, "_zero"}, {31'd0, zero}, {31'd0, zr});
    endtask

    initial begin
        edge_cnt  = 0;
        errors    = 0;
        checks    = 0;
        rst       = 1'b1;
        start     = 1'b0;
        alu_op    = 1'b0;
        operand_a = 16'h0000;
        operand_b = 16'h0000;
        repeat (2) @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_result", {16'd0, result}, 32'd0);
        chk("reset_result_hi", {16'd0, result_hi}, 32'd0);
        chk("reset_flags", {29'd0, overflow, div_by_zero, zero}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 300 x 200 = 60000, busy during cycles 1..16
        issue(1'b1, 16'h012C, 16'h00C8);
        wait_done(rel, nbusy);
        chk("mul1_latency", rel, 32'd17);
        chk("mul1_busy_cycles", nbusy, 32'd16);
        chk_outs("mul1", 16'hEA60, 16'h0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("mul1_done_pulse", {31'd0, done}, 32'd0);
        chk("mul1_hold", {16'd0, result}, 32'h0000EA60);

        issue(1'b1, 16'h1234, 16'h0100);
        wait_done(rel, nbusy);
        chk_outs("mul2", 16'h3400, 16'h0012, 1'b1, 1'b0, 1'b0);
        @(negedge clk);

        issue(1'b1, 16'h0000, 16'hFFFF);
        wait_done(rel, nbusy);
        chk_outs("mul_zero", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
        @(negedge clk);

        issue(1'b0, 16'd1000, 16'd7);
        wait_done(rel, nbusy);
        chk("div1_latency", rel, 32'd17);
        chk_outs("div1", 16'h008E, 16'h0006, 1'b0, 1'b0, 1'b0);
        @(negedge clk);

        issue(1'b0, 16'hFFFF, 16'hFFFF);
        wait_done(rel, nbusy);
        chk_outs("div_ffff", 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);

        issue(1'b0, 16'h55AA, 16'h0000);
        wait_done(rel, nbusy);
        chk("div0_latency", rel, 32'd1);
        chk_outs("div0", 16'hFFFF, 16'h55AA, 1'b0, 1'b1, 1'b0);
        @(negedge clk);

        // 5 x 6 with 9 / 2 requests held during cycles 2..10, then accepted in the done cycle
        issue(1'b1, 16'd5, 16'd6);
        @(negedge clk);
        start     = 1'b1;
        alu_op    = 1'b0;
        operand_a = 16'd9;
        operand_b = 16'd2;
        repeat (9) @(negedge clk);
        start = 1'b0;
        wait_done(rel, nbusy);
        chk("b2b_first_latency", rel, 32'd17);
        chk_outs("b2b_first", 16'd30, 16'd0, 1'b0, 1'b0, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(rel, nbusy);
        chk("b2b_second_latency", rel, 32'd34);
        chk_outs("b2b_second", 16'd4, 16'd1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);

        // Reset during a divide discards it
        issue(1'b0, 16'd1000, 16'd7);
        ndone = 0;
        while (int'(edge_cnt - t0) < 8) begin
            if (done) ndone++;
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_outputs", {result, result_hi}, 32'd0);
        chk("rst_mid_flags", {29'd0, overflow, div_by_zero, zero}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            if (done || busy) ndone++;
            @(negedge clk);
        end
        chk("rst_mid_no_done", ndone, 32'd0);

        issue(1'b1, 16'd3, 16'd4);
        wait_done(rel, nbusy);
        chk("after_rst_latency", rel, 32'd17);
        chk_outs("after_rst_mul", 16'd12, 16'd0, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative unsigned multiply/divide execution unit for the 16-bit core. It consumes the ALU opcode produced by the control unit (1 = MUL, 0 = DIV), with operand B already muxed between register and immediate upstream. It runs one shift-add or restoring-subtract step per cycle and returns the result with a start/busy/done handshake to the pipeline stall logic.

Parameters:
l, 16, datapath width in bits; iteration count equals l.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
start  input  1  request pulse; sampled only when not busy
alu_op  input  1  1 = MUL, 0 = DIV; sampled with start
operand_a  input  l  multiplicand / dividend; sampled with start
operand_b  input  l  multiplier / divisor; sampled with start
busy  output  1  high while an operation is in flight
done  output  1  one-cycle pulse; result outputs valid from this cycle
result  output  l  MUL: low half of product; DIV: quotient
result_hi  output  l  MUL: high half of product; DIV: remainder
overflow  output  1  MUL: result_hi != 0; DIV: 0
div_by_zero  output  1  DIV with operand_b == 0; MUL: 0
zero  output  1  result == 0

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Reset: state = IDLE. busy, done, overflow, div_by_zero and zero are 0. result and result_hi are 0. All internal accumulators and counters are cleared.
- States: IDLE, RUN, DONE.
- IDLE: start=1 latches alu_op and both operands, clears the l-bit iteration counter, and moves to RUN. Exception: for DIV with operand_b == 0, go directly to DONE. Start is ignored while rst=1.
- RUN: busy=1. One iteration per cycle. After l iterations (counter == l-1 at the clock edge), move to DONE. start is ignored in RUN, so no new operands are captured.
- MUL step: if multiplier bit 0 is 1, add the multiplicand to the upper half of the 2l-bit accumulator with carry. Then shift the accumulator and the multiplier right by 1. Unsigned arithmetic.
- DIV step: restoring division. Shift {remainder, quotient} left by 1 and form remainder - divisor in l+1 bits. If non-negative, keep the difference and set the quotient LSB to 1. Otherwise restore and set it to 0.
- DONE: lasts exactly one cycle. done=1 and busy=0. result, result_hi and the flags update in this cycle and hold until the next DONE.
- start=1 in the DONE cycle is accepted exactly as in IDLE, so back-to-back operations are allowed. Otherwise DONE returns to IDLE.
- Latency: with start at cycle 0, done=1 at cycle l+1 (cycle 17 for l=16).
- Divide by zero: done=1 at cycle 1. result = all ones. result_hi = operand_a. div_by_zero=1. overflow=0.
- Flags are computed from the final values only; intermediate iterations never drive the outputs.
- Reset mid-operation: rst=1 in any state forces the full reset values on the next edge, and the in-flight operation is discarded. No done pulse is emitted.
- Simultaneous rst and start: rst wins.
- Operands changing after the start cycle have no effect.

Decomposition:
- Package muldiv_pkg holds:
  - the state encoding (IDLE, RUN, DONE; 2 bits);
  - the opcode constants ALU_OP_DIV = 0 and ALU_OP_MUL = 1, matching the control unit encoding;
  - the default width 16.
- One combinational sub-module, muldiv_step, is natural. It takes accumulator/remainder, operand and op, and returns the next-iteration values. It can be unit-tested alone.
- The top level holds the FSM, the counter and the output registers.

Test Plan:
- MUL 300 × 200 (0x012C × 0x00C8), start at cycle 0 -> done at cycle 17; result=0xEA60, result_hi=0x0000, overflow=0, zero=0; busy high cycles 1–16.
- MUL 0x1234 × 0x0100 -> result=0x3400, result_hi=0x0012, overflow=1. MUL 0 × 0xFFFF -> result=0, zero=1.
- DIV 1000 / 7 -> result=142 (0x008E), result_hi=6, div_by_zero=0, done at cycle 17. DIV 0xFFFF / 0xFFFF -> result=1, result_hi=0.
- DIV 0x55AA / 0 -> done at cycle 1; result=0xFFFF, result_hi=0x55AA, div_by_zero=1.
- MUL 5 × 6 started, then start held high with new operands (9 / 2) during cycles 2–10 -> those starts are ignored. A second start asserted in the done cycle (cycle 17) runs 9 / 2 -> second done at cycle 34 with result=4, result_hi=1.
- Start DIV 1000 / 7, assert rst at cycle 8 -> from cycle 9 all outputs are 0, state IDLE, no done pulse. A fresh MUL 3 × 4 afterwards yields 12.
